// File: rtl/cpu_pkg.sv
// Shared CPU-side types and AXI encodings for the fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

endpackage

// File: rtl/im_fetch_master.sv
// Instruction-side AXI4 read master: one single-beat read per PC, word returned to the pipeline.
// Latency: 3 cycles PC-accept to completion with a zero-wait slave; inst_valid follows one cycle later.
// Backpressure: holds PC via pc_stall until the word is delivered; dm_stall parks a captured word in HOLD.
module im_fetch_master
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                ID_W     = 4,
    parameter logic [ID_W-1:0]   FETCH_ID = 4'd0,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    input  logic              dm_stall,
    output logic              pc_stall,
    output logic [DATA_W-1:0] inst_out,
    output logic              inst_valid,
    output logic              fetch_err,
    output logic [ID_W-1:0]   ARID_M0,
    output logic [ADDR_W-1:0] ARADDR_M0,
    output logic [3:0]        ARLEN_M0,
    output logic [2:0]        ARSIZE_M0,
    output logic [1:0]        ARBURST_M0,
    output logic              ARVALID_M0,
    input  logic              ARREADY_M0,
    input  logic [ID_W-1:0]   RID_M0,
    input  logic [DATA_W-1:0] RDATA_M0,
    input  logic [1:0]        RRESP_M0,
    input  logic              RLAST_M0,
    input  logic              RVALID_M0,
    output logic              RREADY_M0
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              kill_q, kill_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic              err_hold_q, err_hold_d;

    logic r_done;
    logic resp_err;

    // Only our own last beat ends a fetch; stray IDs or non-last beats are ignored.
    assign r_done   = RVALID_M0 && RLAST_M0 && (RID_M0 == FETCH_ID);
    assign resp_err = (RRESP_M0 != AXI_RESP_OKAY);

    assign ARID_M0    = FETCH_ID;
    assign ARADDR_M0  = addr_q;
    assign ARLEN_M0   = 4'd0;
    assign ARSIZE_M0  = AXI_SIZE_WORD;
    assign ARBURST_M0 = AXI_BURST_INCR;

    assign inst_out   = inst_q;
    assign inst_valid = inst_valid_q;
    assign fetch_err  = fetch_err_q;

    // Next-state, kill tracking, capture and handshake outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        kill_d       = kill_q;
        inst_d       = inst_q;
        err_hold_d   = err_hold_q;
        inst_valid_d = 1'b0;
        fetch_err_d  = 1'b0;
        pc_stall     = 1'b1;
        ARVALID_M0   = 1'b0;
        RREADY_M0    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!dm_stall) begin
                    addr_d  = pc_in;
                    state_d = AR;
                end
            end
            AR: begin
                // An issued AR cannot be withdrawn, so a flush only marks it stale.
                ARVALID_M0 = 1'b1;
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (ARREADY_M0) begin
                    state_d = R;
                end
            end
            R: begin
                RREADY_M0 = 1'b1;
                if (r_done) begin
                    if (kill_q || flush) begin
                        // Stale word: drop it but release the PC so the redirect proceeds.
                        kill_d   = 1'b0;
                        pc_stall = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        inst_d     = resp_err ? NOP_INST : RDATA_M0;
                        err_hold_d = resp_err;
                        if (!dm_stall) begin
                            pc_stall     = 1'b0;
                            inst_valid_d = 1'b1;
                            fetch_err_d  = resp_err;
                            state_d      = IDLE;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end else if (flush) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (!dm_stall) begin
                    pc_stall     = 1'b0;
                    inst_valid_d = 1'b1;
                    fetch_err_d  = err_hold_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            kill_q       <= 1'b0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
            err_hold_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            kill_q       <= kill_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q  <= fetch_err_d;
            err_hold_q   <= err_hold_d;
        end
    end

endmodule
